// File: rtl/audio_gain_buffer.sv
// audio_gain_buffer: stereo saturating gain with per-sample ramp, bypass and show-ahead output buffer
module audio_gain_buffer #(
  parameter int DATA_W    = 32,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 12,
  parameter int RAMP_STEP = 256,
  parameter int DEPTH     = 4
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       audio_in_available,
  input  logic [DATA_W-1:0]          audio_in_L,
  input  logic [DATA_W-1:0]          audio_in_R,
  output logic                       read_audio_in,
  input  logic                       audio_out_allowed,
  output logic                       write_audio_out,
  output logic [DATA_W-1:0]          audio_out_L,
  output logic [DATA_W-1:0]          audio_out_R,
  input  logic                       mute,
  input  logic                       bypass,
  input  logic [GAIN_W-1:0]          gain_target,
  input  logic                       clear_clip,
  output logic                       clip_flag,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = DATA_W + GAIN_W + 1;
  localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  function automatic logic [DATA_W:0] scale(input logic [DATA_W-1:0] x, input logic [GAIN_W-1:0] g);
    logic signed [PW-1:0] p;
    logic                 ovf;
    p   = (PW'($signed(x)) * PW'($signed({1'b0, g}))) >>> GAIN_FRAC;
    ovf = p[PW-1:DATA_W-1] != {(PW-DATA_W+1){p[DATA_W-1]}};
    return ovf ? {1'b1, p[PW-1] ? S_MIN : S_MAX} : {1'b0, p[DATA_W-1:0]};
  endfunction
  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]       s1_l_q, s1_l_d, s1_r_q, s1_r_d;
  logic [DATA_W-1:0]       mem_l_q [DEPTH];
  logic [DATA_W-1:0]       mem_l_d [DEPTH];
  logic [DATA_W-1:0]       mem_r_q [DEPTH];
  logic [DATA_W-1:0]       mem_r_d [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [GAIN_W-1:0]       gain_cur_q, gain_cur_d;
  logic                    clip_q, clip_d;
  logic [DATA_W:0]         sc_l, sc_r;
  logic [GAIN_W-1:0]       eff, diff, delta;
  logic                    up, not_empty;
  assign not_empty       = level_q != '0;
  assign read_audio_in   = audio_in_available & ~reset &
                           (({1'b0, level_q} + (LW+1)'(s1_valid_q)) < (LW+1)'(DEPTH));
  assign write_audio_out = audio_out_allowed & ~reset & not_empty;
  assign audio_out_L     = not_empty ? mem_l_q[rd_ptr_q] : '0;
  assign audio_out_R     = not_empty ? mem_r_q[rd_ptr_q] : '0;
  assign fifo_level      = level_q;
  assign clip_flag       = clip_q;
  // Scale the incoming pair with the pre-update gain and step the gain toward its target.
  always_comb begin
    sc_l       = scale(audio_in_L, gain_cur_q);
    sc_r       = scale(audio_in_R, gain_cur_q);
    eff        = mute ? '0 : gain_target;
    up         = eff > gain_cur_q;
    diff       = up ? eff - gain_cur_q : gain_cur_q - eff;
    delta      = diff < GAIN_W'(RAMP_STEP) ? diff : GAIN_W'(RAMP_STEP);
    gain_cur_d = (read_audio_in & ~bypass) ? (up ? gain_cur_q + delta : gain_cur_q - delta) : gain_cur_q;
    s1_valid_d = read_audio_in;
    s1_l_d     = read_audio_in ? (bypass ? audio_in_L : sc_l[DATA_W-1:0]) : s1_l_q;
    s1_r_d     = read_audio_in ? (bypass ? audio_in_R : sc_r[DATA_W-1:0]) : s1_r_q;
    clip_d     = (read_audio_in & ~bypass & (sc_l[DATA_W] | sc_r[DATA_W])) ? 1'b1 : clear_clip ? 1'b0 : clip_q;
  end
  // Push stage-1 into the buffer tail and pop the head when the codec takes it.
  always_comb begin
    mem_l_d  = mem_l_q;
    mem_r_d  = mem_r_q;
    if (s1_valid_q) begin
      mem_l_d[wr_ptr_q] = s1_l_q;
      mem_r_d[wr_ptr_q] = s1_r_q;
    end
    wr_ptr_d = wr_ptr_q + AW'(s1_valid_q);
    rd_ptr_d = rd_ptr_q + AW'(write_audio_out);
    level_d  = level_q + LW'(s1_valid_q) - LW'(write_audio_out);
  end
  // State registers; reset drops the in-flight sample and the whole buffer.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_l_q     <= '0;
      s1_r_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      gain_cur_q <= '0;
      clip_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_l_q[i] <= '0;
        mem_r_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_l_q     <= s1_l_d;
      s1_r_q     <= s1_r_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      gain_cur_q <= gain_cur_d;
      clip_q     <= clip_d;
      mem_l_q    <= mem_l_d;
      mem_r_q    <= mem_r_d;
    end
  end
endmodule

// File: tb/tb_audio_gain_buffer.sv
// tb_audio_gain_buffer: directed checks of gain, ramp, clip, bypass and buffering
module tb_audio_gain_buffer;
  logic        CLOCK_50 = 1'b0;
  logic        reset, audio_in_available, read_audio_in, audio_out_allowed, write_audio_out;
  logic [31:0] audio_in_L, audio_in_R, audio_out_L, audio_out_R;
  logic        mute, bypass, clear_clip, clip_flag;
  logic [15:0] gain_target;
  logic [2:0]  fifo_level;
  int          errors = 0, checks = 0, nreads;
  audio_gain_buffer dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .audio_in_available(audio_in_available), .audio_in_L(audio_in_L), .audio_in_R(audio_in_R),
    .read_audio_in(read_audio_in), .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out), .audio_out_L(audio_out_L), .audio_out_R(audio_out_R),
    .mute(mute), .bypass(bypass), .gain_target(gain_target), .clear_clip(clear_clip),
    .clip_flag(clip_flag), .fifo_level(fifo_level)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask
  task automatic stream(input int n);
    audio_in_available = 1'b1;
    audio_out_allowed  = 1'b1;
    repeat (n) tick();
    audio_in_available = 1'b0;
    repeat (3) tick();
  endtask
  initial begin
    reset = 1'b1; audio_in_available = 1'b1; audio_out_allowed = 1'b1;
    audio_in_L = '0; audio_in_R = '0; mute = 1'b0; bypass = 1'b0;
    gain_target = '0; clear_clip = 1'b0;
    repeat (2) tick();
    chk("rst_read", 32'(read_audio_in), 0);
    chk("rst_write", 32'(write_audio_out), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_out_l", audio_out_L, 0);
    chk("rst_clip", 32'(clip_flag), 0);
    reset = 1'b0; audio_out_allowed = 1'b0; gain_target = 16'd4096;
    audio_in_L = 32'd1000; audio_in_R = -32'sd1000; audio_in_available = 1'b1;
    #1;
    chk("ss_read", 32'(read_audio_in), 1);
    tick(); tick();
    audio_in_available = 1'b0;
    chk("ss_level1", 32'(fifo_level), 1);
    chk("ss_out0_l", audio_out_L, 0);
    chk("ss_out0_r", audio_out_R, 0);
    chk("ss_nowrite", 32'(write_audio_out), 0);
    tick();
    chk("ss_level2", 32'(fifo_level), 2);
    audio_out_allowed = 1'b1;
    #1;
    chk("ss_write", 32'(write_audio_out), 1);
    tick();
    chk("ss_out1_l", audio_out_L, 32'd62);
    chk("ss_out1_r", audio_out_R, -32'sd63);
    tick();
    chk("ss_empty_write", 32'(write_audio_out), 0);
    chk("ss_empty_out", audio_out_L, 0);
    gain_target = 16'd8192; audio_in_L = 32'd100; audio_in_R = -32'sd100;
    stream(40);
    chk("g8k_noclip", 32'(clip_flag), 0);
    audio_out_allowed = 1'b0; audio_in_L = 32'h7FFF_FFFF; audio_in_R = -32'sd3; audio_in_available = 1'b1;
    tick();
    audio_in_available = 1'b0;
    chk("clip_set", 32'(clip_flag), 1);
    tick();
    chk("sat_l", audio_out_L, 32'h7FFF_FFFF);
    chk("sat_r", audio_out_R, 32'hFFFF_FFFA);
    audio_in_L = 32'd100; audio_in_R = 32'd100; audio_in_available = 1'b1;
    tick();
    audio_in_available = 1'b0;
    tick();
    chk("clip_sticky", 32'(clip_flag), 1);
    chk("clip_level", 32'(fifo_level), 2);
    audio_out_allowed = 1'b1;
    repeat (3) tick();
    chk("clip_drain", 32'(fifo_level), 0);
    clear_clip = 1'b1;
    tick();
    clear_clip = 1'b0;
    chk("clip_clear", 32'(clip_flag), 0);
    clear_clip = 1'b1; audio_in_L = 32'h7FFF_FFFF; audio_in_available = 1'b1;
    tick();
    clear_clip = 1'b0; audio_in_available = 1'b0;
    chk("clip_setwins", 32'(clip_flag), 1);
    repeat (3) tick();
    clear_clip = 1'b1;
    tick();
    clear_clip = 1'b0;
    gain_target = 16'd2048; audio_in_L = 32'd100; audio_in_R = 32'd100;
    stream(30);
    audio_out_allowed = 1'b0; audio_in_L = -32'sd3; audio_in_R = 32'd3; audio_in_available = 1'b1;
    tick();
    audio_in_available = 1'b0;
    tick();
    chk("half_l", audio_out_L, 32'hFFFF_FFFE);
    chk("half_r", audio_out_R, 32'd1);
    audio_out_allowed = 1'b1;
    repeat (3) tick();
    audio_out_allowed = 1'b0; bypass = 1'b1; gain_target = 16'd4096;
    audio_in_L = 32'hDEAD_BEEF; audio_in_R = 32'hDEAD_BEEF; audio_in_available = 1'b1;
    tick(); tick();
    audio_in_available = 1'b0;
    tick();
    chk("byp_l", audio_out_L, 32'hDEAD_BEEF);
    chk("byp_r", audio_out_R, 32'hDEAD_BEEF);
    chk("byp_level", 32'(fifo_level), 2);
    chk("byp_noclip", 32'(clip_flag), 0);
    audio_out_allowed = 1'b1;
    repeat (3) tick();
    bypass = 1'b0; audio_out_allowed = 1'b0;
    audio_in_L = 32'd4096; audio_in_R = -32'sd4096; audio_in_available = 1'b1;
    tick();
    audio_in_available = 1'b0;
    tick();
    chk("byp_hold_l", audio_out_L, 32'd2048);
    chk("byp_hold_r", audio_out_R, -32'sd2048);
    audio_out_allowed = 1'b1;
    repeat (3) tick();
    audio_in_L = 32'd100; audio_in_R = 32'd100;
    stream(12);
    mute = 1'b1; audio_in_L = 32'd4096; audio_in_R = 32'd4096;
    audio_out_allowed = 1'b1; audio_in_available = 1'b1;
    tick();
    for (int k = 0; k < 18; k++) begin
      tick();
      chk($sformatf("mute_%0d", k), audio_out_L, (k < 16) ? 32'(4096 - 256 * k) : 32'd0);
    end
    audio_in_available = 1'b0; mute = 1'b0;
    repeat (3) tick();
    chk("mute_drain", 32'(fifo_level), 0);
    bypass = 1'b1; audio_out_allowed = 1'b0; nreads = 0;
    for (int i = 1; i <= 6; i++) begin
      audio_in_L = 32'(i); audio_in_R = -32'(i); audio_in_available = 1'b1;
      #1;
      if (read_audio_in) nreads++;
      tick();
    end
    chk("fill_reads", 32'(nreads), 4);
    chk("fill_read0", 32'(read_audio_in), 0);
    chk("fill_level", 32'(fifo_level), 4);
    chk("fill_head", audio_out_L, 32'd1);
    audio_out_allowed = 1'b1;
    #1;
    chk("full_write", 32'(write_audio_out), 1);
    chk("no_credit", 32'(read_audio_in), 0);
    tick();
    chk("order_2", audio_out_L, 32'd2);
    chk("resume_read", 32'(read_audio_in), 1);
    tick();
    chk("order_3", audio_out_L, 32'd3);
    tick();
    chk("order_4", audio_out_L, 32'd4);
    chk("order_4r", audio_out_R, -32'sd4);
    tick();
    chk("order_6", audio_out_L, 32'd6);
    audio_in_available = 1'b0;
    repeat (4) tick();
    audio_out_allowed = 1'b0; audio_in_L = 32'd7; audio_in_available = 1'b1;
    repeat (3) tick();
    audio_in_available = 1'b0;
    repeat (2) tick();
    chk("pre_rst_level", 32'(fifo_level), 3);
    reset = 1'b1; audio_out_allowed = 1'b1; audio_in_available = 1'b1;
    #1;
    chk("mid_rst_write", 32'(write_audio_out), 0);
    chk("mid_rst_read", 32'(read_audio_in), 0);
    tick();
    reset = 1'b0; audio_in_available = 1'b0;
    #1;
    chk("post_rst_level", 32'(fifo_level), 0);
    chk("post_rst_out", audio_out_L, 0);
    chk("post_rst_write", 32'(write_audio_out), 0);
    bypass = 1'b0; audio_out_allowed = 1'b0; gain_target = 16'd4096;
    audio_in_L = 32'd1000; audio_in_R = 32'd1000; audio_in_available = 1'b1;
    tick(); tick();
    audio_in_available = 1'b0;
    tick();
    chk("rst_ramp0", audio_out_L, 0);
    chk("rst_ramp_level", 32'(fifo_level), 2);
    audio_out_allowed = 1'b1;
    tick();
    chk("rst_ramp1", audio_out_L, 32'd62);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
